ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit.sv | 131 +++++++++++++
 tb/tb_ifetch_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: fetch PC, combinational instruction memory port, 2-entry {pc, word} buffer.
// Optional address bounds check with fault/halt enabled by `IFETCH_BOUNDS_CHECK_EN; `MEM_DEPTH sets the default memory size.
`ifndef MEM_DEPTH
`define MEM_DEPTH 4096
`endif

module ifetch_unit #(
    parameter logic [31:0] START_ADDR = 32'h0100_0000,
    parameter int unsigned MEM_DEPTH  = `MEM_DEPTH
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] imem_address,
    output logic        imem_read_write,
    input  logic [31:0] imem_data_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_word,
    output logic        fetch_fault
);

    typedef enum logic {RUN, HALT} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    state_t      state;
    state_t      state_next;
    logic        fetch_en;
    logic [31:0] pc;
    logic [1:0]  count;
    entry_t      fifo [2];
    entry_t      fetched;
    logic        pop;
    logic        room;
    logic        eligible;
    logic        bad_pc;
    logic        push;
    logic        fault_take;

    assign imem_address    = pc;
    assign imem_read_write = 1'b0;

    assign inst_valid = (count != 2'd0);
    assign inst_pc    = inst_valid ? fifo[0].pc   : 32'd0;
    assign inst_word  = inst_valid ? fifo[0].word : 32'd0;

`ifdef IFETCH_BOUNDS_CHECK_EN
    logic [32:0] span;
    assign span   = {1'b0, pc - START_ADDR} + 33'd3;
    assign bad_pc = (pc[1:0] != 2'b00) || (pc < START_ADDR) || (span >= 33'(MEM_DEPTH));
`else
    assign bad_pc = 1'b0;
`endif

    // A full buffer still has room when the head leaves on the same edge.
    assign pop        = inst_valid && inst_ready;
    assign room       = (count != 2'd2) || pop;
    assign eligible   = fetch_en && !redirect_valid && room;
    assign push       = eligible && !bad_pc;
    assign fault_take = eligible && bad_pc;
    assign fetched    = '{pc: pc, word: imem_data_in};

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        if (redirect_valid) begin
            state_next = RUN;
        end else if (fault_take) begin
            state_next = HALT;
        end
    end

    always_comb begin
        fetch_en = (state == RUN);
`ifdef IFETCH_BOUNDS_CHECK_EN
        fetch_fault = (state == HALT);
`else
        fetch_fault = 1'b0;
`endif
    end

    // NOTE: buffer storage is not reset; count gates every read, so stale data never escapes.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc    <= START_ADDR;
            count <= 2'd0;
        end else if (redirect_valid) begin
            pc    <= redirect_pc;
            count <= 2'd0;
        end else begin
            if (push) begin
                pc <= pc + 32'd4;
            end
            case ({push, pop})
                2'b10: begin
                    fifo[count[0]] <= fetched;
                    count          <= count + 2'd1;
                end
                2'b01: begin
                    fifo[0] <= fifo[1];
                    count   <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        fifo[0] <= fifo[1];
                        fifo[1] <= fetched;
                    end else begin
                        fifo[0] <= fetched;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus random traffic against a queue-based reference model.
// The model applies the bounds-check rules only when IFETCH_BOUNDS_CHECK_EN is defined.
module tb_ifetch_unit;

    localparam logic [31:0] START = 32'h0100_0000;
    localparam int unsigned DEPTH = 16;
`ifdef IFETCH_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } ent_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] imem_address;
    logic        imem_read_write;
    logic [31:0] imem_data_in;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_pc;
    logic [31:0] inst_word;
    logic        fetch_fault;

    int errors = 0;
    int checks = 0;

    logic [31:0] rom [4];
    ent_t        q [$];
    logic [31:0] m_pc;
    bit          m_halt;

    ifetch_unit #(
        .START_ADDR(START),
        .MEM_DEPTH (DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_address   (imem_address),
        .imem_read_write(imem_read_write),
        .imem_data_in   (imem_data_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_pc        (inst_pc),
        .inst_word      (inst_word),
        .fetch_fault    (fetch_fault)
    );

    always #5 clock = ~clock;

    function automatic longint offset_of(input logic [31:0] a);
        return longint'(a) - longint'(START);
    endfunction

    function automatic bit is_bad(input logic [31:0] a);
        longint off;
        off = offset_of(a);
        return (a[1:0] != 2'b00) || (off < 0) || (off + 3 >= longint'(DEPTH));
    endfunction

    // Memory returns the ROM word for in-range aligned addresses, 0 elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        longint off;
        off = offset_of(a);
        if (!is_bad(a)) return rom[int'(off / 4)];
        return 32'd0;
    endfunction

    assign imem_data_in = mem_word(imem_address);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input bit rv, input logic [31:0] rpc, input bit rdy);
        bit pop;
        bit eligible;
        if (rst) begin
            q.delete();
            m_pc   = START;
            m_halt = 1'b0;
        end else if (rv) begin
            q.delete();
            m_pc   = rpc;
            m_halt = 1'b0;
        end else begin
            pop      = (q.size() > 0) && rdy;
            eligible = !m_halt && ((q.size() < 2) || pop);
            if (pop) void'(q.pop_front());
            if (eligible) begin
                if (BOUNDS && is_bad(m_pc)) begin
                    m_halt = 1'b1;
                end else begin
                    q.push_back('{pc: m_pc, word: mem_word(m_pc)});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic check_outputs();
        bit has;
        has = (q.size() > 0);
        check("inst_valid", {31'd0, inst_valid}, {31'd0, has});
        check("inst_pc", inst_pc, has ? q[0].pc : 32'd0);
        check("inst_word", inst_word, has ? q[0].word : 32'd0);
        check("imem_address", imem_address, m_pc);
        check("imem_read_write", {31'd0, imem_read_write}, 32'd0);
        check("fetch_fault", {31'd0, fetch_fault}, {31'd0, BOUNDS && m_halt});
    endtask

    task automatic cycle(input bit rst, input bit rv, input logic [31:0] rpc, input bit rdy);
        reset          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        inst_ready     = rdy;
        @(posedge clock);
        model_edge(rst, rv, rpc, rdy);
        @(negedge clock);
        check_outputs();
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 9))
            0:       return START + 32'd1;
            1:       return START - 32'd4;
            2:       return 32'hFFFF_FFF8;
            3:       return START + 32'd16;
            default: return START + 32'(4 * $urandom_range(0, 3));
        endcase
    endfunction

    initial begin
        rom[0] = 32'h0000_0013;
        rom[1] = 32'h0010_0093;
        rom[2] = 32'h0020_8133;
        rom[3] = 32'h4000_01B7;
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        inst_ready = 1'b0;
        m_pc = START;
        m_halt = 1'b0;
        @(negedge clock);

        // Reset state, then one instruction per cycle
        cycle(1, 0, 32'd0, 0);
        cycle(1, 0, 32'd0, 0);
        check("reset_address", imem_address, START);
        check("reset_valid", {31'd0, inst_valid}, 32'd0);
        cycle(0, 0, 32'd0, 1);
        check("first_pc", inst_pc, START);
        check("first_word", inst_word, 32'h0000_0013);
        cycle(0, 0, 32'd0, 1);
        check("second_pc", inst_pc, START + 32'd4);
        check("second_word", inst_word, 32'h0010_0093);

        // Stall with a full buffer, then push and pop together
        cycle(1, 0, 32'd0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 32'd0, 0);
        check("stall_address", imem_address, START + 32'd8);
        check("stall_head", inst_pc, START);
        cycle(0, 0, 32'd0, 1);
        check("pushpop_head", inst_pc, START + 32'd4);
        check("pushpop_address", imem_address, START + 32'd12);

        // Redirect while full discards both entries
        cycle(0, 1, START + 32'h40, 1);
        check("redirect_flush", {31'd0, inst_valid}, 32'd0);
        cycle(0, 0, 32'd0, 1);
        if (BOUNDS) check("redirect_fault", {31'd0, fetch_fault}, 32'd1);
        else        check("redirect_pc", inst_pc, START + 32'h40);

        // Reset wins over a simultaneous redirect
        cycle(1, 1, START + 32'h40, 0);
        check("reset_over_redirect", imem_address, START);

        // Free run to the end of memory, then redirect back
        for (int i = 0; i < 6; i++) cycle(0, 0, 32'd0, 1);
        check("freerun_address", imem_address, BOUNDS ? START + 32'd16 : START + 32'd24);
        check("freerun_fault", {31'd0, fetch_fault}, {31'd0, BOUNDS});
        cycle(0, 1, START, 1);
        check("fault_cleared", {31'd0, fetch_fault}, 32'd0);
        cycle(0, 0, 32'd0, 1);
        check("restart_pc", inst_pc, START);

        // PC wraps past the top of the address space
        cycle(0, 1, 32'hFFFF_FFF8, 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 32'd0, 1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
                  pick_target(), $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
